// File: rtl/iter_alu_exec_if.sv
// Operand/result handshake bundle for iter_alu_exec.
// master drives operations in and accepts results; slave is the execute unit.
interface iter_alu_exec_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             alu_err;

    modport master (
        output in_valid, ALUControl, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, ALUResult, Zero, alu_err
    );

    modport slave (
        input  in_valid, ALUControl, SrcA, SrcB, out_ready,
        output in_ready, out_valid, ALUResult, Zero, alu_err
    );
endinterface

// File: rtl/iter_alu_exec.sv
// Execute-stage ALU with valid/ready handshake; shifts iterate 1 bit/cycle unless
// ITER_ALU_BARREL_SHIFT_EN is defined, which computes them in one cycle instead.
module iter_alu_exec #(
    parameter int unsigned WIDTH = 32
) (
    input logic          clk,
    input logic          reset,
    iter_alu_exec_if.slave bus
);
    localparam int unsigned ShW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] alu_res;
    logic             alu_bad;
    logic             is_shift;
    logic [ShW-1:0]   shamt;

    assign shamt    = bus.SrcB[ShW-1:0];
    assign is_shift = (bus.ALUControl == 4'b1000) || (bus.ALUControl == 4'b1001) ||
                      (bus.ALUControl == 4'b1010);

    always_comb begin
        alu_res = '0;
        alu_bad = 1'b0;
        unique case (bus.ALUControl)
            4'b0000: alu_res = bus.SrcA + bus.SrcB;
            4'b0001: alu_res = bus.SrcA - bus.SrcB;
            4'b0010: alu_res = bus.SrcA & bus.SrcB;
            4'b0011: alu_res = bus.SrcA | bus.SrcB;
            4'b0110: alu_res = bus.SrcA ^ bus.SrcB;
            4'b0101: alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.SrcA) < $signed(bus.SrcB)};
            4'b0111: alu_res = {{(WIDTH-1){1'b0}}, bus.SrcA < bus.SrcB};
`ifdef ITER_ALU_BARREL_SHIFT_EN
            4'b1000: alu_res = bus.SrcA << shamt;
            4'b1001: alu_res = bus.SrcA >> shamt;
            4'b1010: alu_res = $unsigned($signed(bus.SrcA) >>> shamt);
`else
            // Only reached directly for shamt == 0; longer shifts go through StShift.
            4'b1000, 4'b1001, 4'b1010: alu_res = bus.SrcA;
`endif
            default: alu_bad = 1'b1;
        endcase
    end

`ifndef ITER_ALU_BARREL_SHIFT_EN
    logic [WIDTH-1:0] shreg_q, shreg_d, shreg_step;
    logic [ShW-1:0]   cnt_q, cnt_d;
    logic [1:0]       kind_q, kind_d;

    always_comb begin
        unique case (kind_q)
            2'b00:   shreg_step = {shreg_q[WIDTH-2:0], 1'b0};
            2'b01:   shreg_step = {1'b0, shreg_q[WIDTH-1:1]};
            default: shreg_step = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            kind_q  <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        err_d    = err_q;
`ifndef ITER_ALU_BARREL_SHIFT_EN
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        kind_d   = kind_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    err_d = alu_bad;
`ifndef ITER_ALU_BARREL_SHIFT_EN
                    if (is_shift && (shamt != '0)) begin
                        shreg_d = bus.SrcA;
                        cnt_d   = shamt;
                        kind_d  = bus.ALUControl[1:0];
                        state_d = StShift;
                    end else
`endif
                    begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        state_d  = StDone;
                    end
                end
            end
`ifndef ITER_ALU_BARREL_SHIFT_EN
            StShift: begin
                shreg_d = shreg_step;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == ShW'(1)) begin
                    result_d = shreg_step;
                    zero_d   = (shreg_step == '0);
                    state_d  = StDone;
                end
            end
`endif
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            result_q <= '0;
            zero_q   <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

`ifdef ITER_ALU_BARREL_SHIFT_EN
    logic unused_is_shift;
    assign unused_is_shift = is_shift;
`endif

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.ALUResult = result_q;
    assign bus.Zero      = zero_q;
    assign bus.alu_err   = err_q;
endmodule
